// File: rtl/sha_round_ctrl.sv
// Sequencer for one SHA-256 block: hash init, 16-word message load, 64 rounds,
// final hash update and a done pulse, with a start/done handshake and a synchronous abort.
module sha_round_ctrl #(
  parameter int DATA_W   = 32,
  parameter int N_WORDS  = 16,
  parameter int N_ROUNDS = 64,
  parameter int CNT_SIZE = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  input  logic                       i_first,
  input  logic                       i_abort,
  input  logic                       i_msg_valid,
  input  logic [DATA_W-1:0]          i_msg_data,
  output logic                       o_msg_ready,
  output logic                       o_w_wr_en,
  output logic [$clog2(N_WORDS)-1:0] o_w_addr,
  output logic [DATA_W-1:0]          o_w_data,
  output logic                       o_hash_init,
  output logic                       o_round_en,
  output logic [CNT_SIZE-1:0]        o_round_idx,
  output logic                       o_hash_upd,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int ADDR_W = $clog2(N_WORDS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [ADDR_W-1:0]   LAST_WORD  = ADDR_W'(N_WORDS - 1);
  localparam logic [CNT_SIZE-1:0] LAST_ROUND = CNT_SIZE'(N_ROUNDS - 1);

  logic [2:0]          state;
  logic [2:0]          state_nx;
  logic [ADDR_W-1:0]   word_cnt;
  logic [CNT_SIZE-1:0] round_cnt;
  logic                first_q;
  logic                accept;
  logic                last_word;
  logic                last_round;

  assign accept     = (state == S_LOAD) && i_msg_valid;
  assign last_word  = (word_cnt == LAST_WORD);
  assign last_round = (round_cnt == LAST_ROUND);

  // NOTE: state_nx gets a default before the case so no path can leave it unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (i_start)                state_nx = S_INIT;
      S_INIT:                               state_nx = S_LOAD;
      S_LOAD:   if (accept && last_word)    state_nx = S_ROUND;
      S_ROUND:  if (last_round)             state_nx = S_UPDATE;
      S_UPDATE:                             state_nx = S_DONE;
      S_DONE:                               state_nx = S_IDLE;
      default:                              state_nx = S_IDLE;
    endcase
    // Abort overrides every transition, including a start arriving in IDLE.
    if (i_abort) state_nx = S_IDLE;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      round_cnt <= '0;
      first_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (i_abort) begin
        word_cnt  <= '0;
        round_cnt <= '0;
      end else begin
        if (accept) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        if (state == S_ROUND) round_cnt <= last_round ? '0 : round_cnt + 1'b1;
        if (state == S_IDLE && i_start) first_q <= i_first;
      end
    end
  end

  // Write path is the only Mealy part: the strobe follows i_msg_valid within the cycle.
  assign o_msg_ready = (state == S_LOAD);
  assign o_w_wr_en   = accept;
  assign o_w_addr    = (state == S_LOAD) ? word_cnt : '0;
  assign o_w_data    = i_msg_data;

  assign o_hash_init = (state == S_INIT) && first_q;
  assign o_round_en  = (state == S_ROUND);
  assign o_round_idx = (state == S_ROUND) ? round_cnt : '0;
  assign o_hash_upd  = (state == S_UPDATE);
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Self-checking bench for sha_round_ctrl: directed scenarios plus random stimulus,
// compared cycle by cycle against a counter-based block model.
module tb_sha_round_ctrl;

  localparam int DATA_W   = 32;
  localparam int N_WORDS  = 16;
  localparam int N_ROUNDS = 64;
  localparam int CNT_SIZE = 6;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                i_start, i_first, i_abort, i_msg_valid;
  logic [DATA_W-1:0]   i_msg_data;
  logic                o_msg_ready, o_w_wr_en, o_hash_init, o_round_en;
  logic                o_hash_upd, o_busy, o_done;
  logic [3:0]          o_w_addr;
  logic [DATA_W-1:0]   o_w_data;
  logic [CNT_SIZE-1:0] o_round_idx;

  sha_round_ctrl #(
    .DATA_W(DATA_W), .N_WORDS(N_WORDS), .N_ROUNDS(N_ROUNDS), .CNT_SIZE(CNT_SIZE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_first(i_first),
    .i_abort(i_abort), .i_msg_valid(i_msg_valid), .i_msg_data(i_msg_data),
    .o_msg_ready(o_msg_ready), .o_w_wr_en(o_w_wr_en), .o_w_addr(o_w_addr),
    .o_w_data(o_w_data), .o_hash_init(o_hash_init), .o_round_en(o_round_en),
    .o_round_idx(o_round_idx), .o_hash_upd(o_hash_upd), .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Block model: a block is "age" cycles old, has taken "words" message words,
  // and has spent "k" cycles since the last word (rounds, then update, then done).
  bit m_active;
  bit m_first;
  int m_age, m_words, m_k;

  int cyc;
  bit seen_done;
  int wr_count;
  int done_count;
  int upd_count;
  int done_cycles[$];

  task automatic model_reset();
    m_active = 1'b0; m_first = 1'b0; m_age = 0; m_words = 0; m_k = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(o_busy),      0);
    check({tag, "_hash_init"}, 32'(o_hash_init), 0);
    check({tag, "_msg_ready"}, 32'(o_msg_ready), 0);
    check({tag, "_w_wr_en"},   32'(o_w_wr_en),   0);
    check({tag, "_w_addr"},    32'(o_w_addr),    0);
    check({tag, "_round_en"},  32'(o_round_en),  0);
    check({tag, "_round_idx"}, 32'(o_round_idx), 0);
    check({tag, "_hash_upd"},  32'(o_hash_upd),  0);
    check({tag, "_done"},      32'(o_done),      0);
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
  task automatic step(input bit st, input bit fi, input bit ab, input bit va);
    bit ld, rd, fin;
    logic [DATA_W-1:0] d;
    d = $urandom;
    i_start = st; i_first = fi; i_abort = ab; i_msg_valid = va; i_msg_data = d;
    @(negedge clk);
    ld  = m_active && m_age >= 1 && m_words < N_WORDS;
    fin = m_active && m_words == N_WORDS;
    rd  = fin && m_k < N_ROUNDS;
    check("busy",      32'(o_busy),      32'(m_active));
    check("hash_init", 32'(o_hash_init), 32'(m_active && m_age == 0 && m_first));
    check("msg_ready", 32'(o_msg_ready), 32'(ld));
    check("w_wr_en",   32'(o_w_wr_en),   32'(ld && va));
    check("w_addr",    32'(o_w_addr),    ld ? m_words : 0);
    if (ld && va) check("w_data", o_w_data, d);
    check("round_en",  32'(o_round_en),  32'(rd));
    check("round_idx", 32'(o_round_idx), rd ? m_k : 0);
    check("hash_upd",  32'(o_hash_upd),  32'(fin && m_k == N_ROUNDS));
    check("done",      32'(o_done),      32'(fin && m_k == N_ROUNDS + 1));
    seen_done = o_done;
    if (o_w_wr_en)  wr_count++;
    if (o_done)     begin done_count++; done_cycles.push_back(cyc); end
    if (o_hash_upd) upd_count++;
    if (!m_active) begin
      if (st && !ab) begin
        m_active = 1'b1; m_age = 0; m_words = 0; m_k = 0; m_first = fi;
      end
    end else if (ab) begin
      m_active = 1'b0;
    end else begin
      if (ld) begin
        if (va) m_words++;
      end else if (m_words == N_WORDS) begin
        m_k++;
        if (m_k > N_ROUNDS + 1) m_active = 1'b0;
      end
      m_age++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Start a block and return cycles from the start edge to the o_done cycle (-1 on timeout).
  task automatic run_block(input bit fi, input bit toggle, output int lat);
    bit va;
    step(1'b1, fi, 1'b0, 1'b1);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      va = toggle ? (n % 2 == 0) : 1'b1;
      step(1'b0, fi, 1'b0, va);
      if (seen_done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    i_start = 1'b0; i_first = 1'b0; i_abort = 1'b0; i_msg_valid = 1'b0; i_msg_data = '0;
    model_reset();
    cyc = 0; wr_count = 0; done_count = 0; upd_count = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Plain block with H0 load, then one idle cycle
    run_block(1'b1, 1'b0, lat);
    check("lat_first", 32'(lat), 83);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Chained block
    run_block(1'b0, 1'b0, lat);
    check("lat_chain", 32'(lat), 83);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Valid toggling 1/0 during LOAD
    wr_count = 0;
    run_block(1'b1, 1'b1, lat);
    check("lat_toggle", 32'(lat), 98);
    check("toggle_writes", 32'(wr_count), 16);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Abort at round index 30 (cycle 48), then a normal block
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int n = 1; n < 48; n++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_idx", 32'(o_round_idx), 30);
    done_count = 0; upd_count = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 90; n++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_no_done", 32'(done_count), 0);
    check("abort_no_upd",  32'(upd_count), 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_block(1'b1, 1'b0, lat);
    check("lat_after_abort", 32'(lat), 83);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while word 7 is being written
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int n = 1; n < 9; n++) step(1'b0, 1'b0, 1'b0, 1'b1);
    i_start = 1'b0; i_abort = 1'b0; i_msg_valid = 1'b1;
    #2;
    check("pre_rst_wr_en", 32'(o_w_wr_en), 1);
    check("pre_rst_addr",  32'(o_w_addr), 7);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_block(1'b1, 1'b0, lat);
    check("lat_after_rst", 32'(lat), 83);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Start held high: back-to-back blocks every 84 cycles
    done_cycles.delete();
    for (int n = 0; n < 260; n++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("b2b_count", 32'(done_cycles.size()), 3);
    if (done_cycles.size() == 3) begin
      check("b2b_gap0", 32'(done_cycles[1] - done_cycles[0]), 84);
      check("b2b_gap1", 32'(done_cycles[2] - done_cycles[1]), 84);
    end
    i_start = 1'b0;
    for (int n = 0; n < 90; n++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional aborts and stalls
    for (int n = 0; n < 4000; n++)
      step($urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 149) == 0,
           $urandom_range(0, 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha_round_ctrl.md
# sha_round_ctrl

Control unit for one SHA-256 compression. It sequences the message-word load, the 64 round iterations and the final hash update, and drives the round counter/address into the message-schedule and round datapath. It sits between the host-side message interface and the SHA datapath, replacing free-running counter use with a start/done handshake.

## Interface
- DATA_W, 32, message word width
- N_WORDS, 16, message words per block
- N_ROUNDS, 64, compression rounds per block
- CNT_SIZE, 6, width of round index (must satisfy 2^CNT_SIZE >= N_ROUNDS)
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- i_start  input  1  start one block; sampled only in IDLE
- i_first  input  1  sampled with i_start; 1 = load initial hash H0, 0 = chain from previous digest
- i_abort  input  1  synchronous abort; returns to IDLE from any state
- i_msg_valid  input  1  message word valid
- i_msg_data  input  DATA_W  message word
- o_msg_ready  output  1  controller accepts a word this cycle
- o_w_wr_en  output  1  write strobe to W memory
- o_w_addr  output  $clog2(N_WORDS)  W memory write address
- o_w_data  output  DATA_W  i_msg_data passed through
- o_hash_init  output  1  load H0 into working/hash registers
- o_round_en  output  1  datapath performs one round this cycle
- o_round_idx  output  CNT_SIZE  current round index (K/W address)
- o_hash_upd  output  1  add working variables into hash registers
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  one-cycle pulse, digest valid

## Operation
- States: IDLE, INIT, LOAD, ROUND, UPDATE, DONE. Reset (reset_n low, async) forces IDLE, word counter 0, round counter 0, latched first flag 0; all outputs 0.
- IDLE: i_start=1 -> INIT; i_first latched. i_start ignored in any other state.
- INIT: one cycle; o_hash_init = latched first flag; -> LOAD.
- LOAD: o_msg_ready=1. Accept = i_msg_valid & o_msg_ready. o_w_wr_en = accept (combinational), o_w_addr = word counter, o_w_data = i_msg_data. Word counter increments on accept; on accept with counter = N_WORDS-1 -> ROUND, counter clears to 0. i_msg_valid low stalls indefinitely with no effect.
- ROUND: o_round_en=1 every cycle, o_round_idx = round counter starting at 0, +1 per cycle. Cycle with idx = N_ROUNDS-1 -> UPDATE, counter clears to 0. No stall.
- UPDATE: o_hash_upd=1 one cycle -> DONE.
- DONE: o_done=1 one cycle -> IDLE. o_busy=1 in DONE.
- i_abort has priority over every transition: next state IDLE, both counters cleared, no strobe (o_w_wr_en, o_round_en, o_hash_upd, o_done) asserted after the abort edge. Abort in IDLE is a no-op; i_start and i_abort together in IDLE -> stays IDLE.
- All outputs except o_w_wr_en/o_w_data are Moore (decoded from state/counters); o_msg_ready and o_round_idx are 0 outside LOAD/ROUND.

## Timing
- i_start sampled at edge 0 -> INIT during cycle 1, LOAD from cycle 2.
- No LOAD stalls: words accepted cycles 2-17, ROUND cycles 18-81 (idx 0..63), UPDATE cycle 82, DONE cycle 83, IDLE cycle 84. Start-to-done = 83 cycles + number of LOAD stall cycles.
- Back-to-back blocks: i_start accepted earliest in cycle 84; next o_hash_init one cycle later.
- reset_n asserted mid-operation: outputs drop to 0 immediately (async), no o_done for the interrupted block.

## Test plan
- Reset then i_start, i_first=1, valid held high -> o_hash_init in cycle 1, o_w_addr 0..15 in cycles 2-17, o_round_idx 0..63 in cycles 18-81, o_hash_upd cycle 82, o_done cycle 83, o_busy low cycle 84.
- i_first=0 -> o_hash_init stays 0 in INIT; rest identical.
- i_msg_valid toggled 1/0 each cycle in LOAD -> exactly 16 writes, addresses 0..15 in order, o_done at cycle 98.
- i_abort at round idx 30 -> IDLE next cycle, no o_hash_upd/o_done; new i_start then completes normally with idx starting at 0.
- reset_n pulsed low during LOAD word 7 -> all outputs 0 asynchronously; after release, new block writes from address 0.
- i_start held high continuously -> blocks run back-to-back, o_done every 84 cycles, i_start during busy ignored.
